// File: rtl/exibe_sequencia_if.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_if
//   Connects the sequence presenter to the game's top-level unit and the ROM.
//   master : the top-level/ROM side. It drives the start request, the last
//            address and the ROM data, and it observes the presenter outputs.
//   slave  : the presenter (exibe_sequencia).
//   Signals:
//     iniciar   start request
//     limite    last ROM address to show (0..15)
//     mem_dado  ROM data, a combinational read of mem_addr
//     mem_addr  ROM address, registered in the presenter
//     leds      displayed value; 0000 when blank
//     ocupado   high whenever a sequence is in progress
//     fim       one-cycle end-of-sequence pulse
//     db_estado current state code for the debug display
// -----------------------------------------------------------------------------
interface exibe_sequencia_if;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] mem_dado;
    logic [3:0] mem_addr;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    modport master (
        output iniciar, limite, mem_dado,
        input  mem_addr, leds, ocupado, fim, db_estado
    );

    modport slave (
        input  iniciar, limite, mem_dado,
        output mem_addr, leds, ocupado, fim, db_estado
    );
endinterface

// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
//   Presenter side of the memory game. Walks the stored sequence from ROM
//   address 0 up to `limite`. Each entry is lit on the LEDs for T_ON cycles and
//   then blanked for T_OFF cycles. After the last entry, fim pulses for one cycle.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-low
//     bus    exibe_sequencia_if.slave (iniciar, limite, mem_dado in;
//            mem_addr, leds, ocupado, fim, db_estado out)
//   Parameters:
//     T_ON    cycles each entry is lit, >= 1
//     T_OFF   cycles the LEDs stay blank after each entry, >= 1
//     TIMER_W timer width, 2**TIMER_W > max(T_ON, T_OFF)
// -----------------------------------------------------------------------------
module exibe_sequencia #(
    parameter int T_ON    = 25_000_000,
    parameter int T_OFF   = 12_500_000,
    parameter int TIMER_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    exibe_sequencia_if.slave  bus
);

    // State codes double as the debug display value.
    localparam logic [3:0] S_INICIAL = 4'd0;
    localparam logic [3:0] S_CARREGA = 4'd1;
    localparam logic [3:0] S_MOSTRA  = 4'd2;
    localparam logic [3:0] S_APAGA   = 4'd3;
    localparam logic [3:0] S_PROXIMO = 4'd4;
    localparam logic [3:0] S_FIM     = 4'd5;

    localparam logic [TIMER_W-1:0] T_ON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] T_OFF_LAST = TIMER_W'(T_OFF - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    logic [3:0]         state_q, state_d;
    logic [3:0]         addr_q,  addr_d;
    logic [3:0]         leds_q,  leds_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // NOTE: every variable gets its hold value before the case statement, so
    // any path that does not assign it keeps it as a plain mux, not a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        leds_d  = leds_q;
        timer_d = timer_q;

        case (state_q)
            S_INICIAL: begin
                if (bus.iniciar) begin
                    state_d = S_CARREGA;
                    addr_d  = '0;
                    timer_d = '0;
                end
            end

            S_CARREGA: begin
                // mem_dado is captured only here, so later ROM changes do not
                // reach the LEDs.
                leds_d  = bus.mem_dado;
                timer_d = '0;
                state_d = S_MOSTRA;
            end

            S_MOSTRA: begin
                if (timer_q == T_ON_LAST) begin
                    leds_d  = '0;
                    timer_d = '0;
                    state_d = S_APAGA;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_APAGA: begin
                if (timer_q == T_OFF_LAST) begin
                    timer_d = '0;
                    // Equality compare against limite. Address 15 also ends
                    // the run, so a limite lowered below the current address
                    // runs to 15 without wrapping back to 0.
                    if (addr_q == bus.limite || addr_q == 4'hF) begin
                        state_d = S_FIM;
                    end else begin
                        state_d = S_PROXIMO;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_PROXIMO: begin
                addr_d  = addr_q + 4'd1;
                state_d = S_CARREGA;
            end

            S_FIM: begin
                // mem_addr keeps the last address shown until the next start.
                state_d = S_INICIAL;
            end

            default: begin
                state_d = S_INICIAL;
                leds_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_INICIAL;
            addr_q  <= '0;
            leds_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            leds_q  <= leds_d;
            timer_q <= timer_d;
        end
    end

    // Moore outputs, decoded from the state register only.
    assign bus.mem_addr  = addr_q;
    assign bus.leds      = leds_q;
    assign bus.ocupado   = (state_q != S_INICIAL);
    assign bus.fim       = (state_q == S_FIM);
    assign bus.db_estado = state_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// -----------------------------------------------------------------------------
// tb_exibe_sequencia
//   Directed bench for exibe_sequencia with T_ON=3 and T_OFF=2. The ROM holds
//   one-hot entries 0001,0010,0100,1000, repeating, so ROM[15]=1000.
//   One entry takes PER = 1 + T_ON + T_OFF + 1 = 7 cycles. Cycle c counts from
//   the edge that samples iniciar=1. Within that cycle, i=(c-1)/PER is the
//   entry index and k=(c-1)%PER is the phase.
// -----------------------------------------------------------------------------
module tb_exibe_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int PER   = T_ON + T_OFF + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    exibe_sequencia_if bus ();

    exibe_sequencia #(
        .T_ON    (T_ON),
        .T_OFF   (T_OFF),
        .TIMER_W (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ROM model, with an override used to glitch or zero the data.
    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'h0;

    function automatic logic [3:0] rom_val(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << (idx % 4);
    endfunction

    assign bus.mem_dado = ovr_en ? ovr_val : rom_val(int'(bus.mem_addr));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [3:0] limite;
        int         fim_cycle;    // hand-computed (L+1)*(1+T_ON+T_OFF)+L+1
        logic [3:0] last_addr;
        int         repulse;      // cycle with iniciar=1 mid-run, -1 = none
        int         zero_entry;   // entry whose ROM data reads 0000, -1 = none
        bit         glitch;       // drive 1111 on mem_dado during every MOSTRA
        int         drop_cycle;   // cycle at which limite changes, -1 = none
        logic [3:0] drop_val;
    } vec_t;

    // Runs one sequence from INICIAL and checks every cycle up to one past FIM.
    task automatic run_vec(input vec_t v);
        int i, k;
        logic [3:0] exp_leds, exp_addr, exp_db;
        bus.limite  = v.limite;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        for (int c = 1; c <= v.fim_cycle + 1; c++) begin
            i = (c - 1) / PER;
            k = (c - 1) % PER;
            if (c > v.fim_cycle) begin
                exp_leds = 4'h0;
                exp_addr = v.last_addr;
                exp_db   = 4'd0;
            end else begin
                exp_leds = (k >= 1 && k <= T_ON && i != v.zero_entry) ? rom_val(i) : 4'h0;
                exp_addr = 4'(i);
                if (c == v.fim_cycle)   exp_db = 4'd5;
                else if (k == 0)        exp_db = 4'd1;
                else if (k <= T_ON)     exp_db = 4'd2;
                else if (k < PER - 1)   exp_db = 4'd3;
                else                    exp_db = 4'd4;
            end
            check($sformatf("%s c%0d leds", v.name, c), 32'(bus.leds), 32'(exp_leds));
            check($sformatf("%s c%0d addr", v.name, c), 32'(bus.mem_addr), 32'(exp_addr));
            check($sformatf("%s c%0d fim", v.name, c), 32'(bus.fim), 32'(c == v.fim_cycle));
            check($sformatf("%s c%0d ocupado", v.name, c), 32'(bus.ocupado), 32'(c <= v.fim_cycle));
            check($sformatf("%s c%0d db_estado", v.name, c), 32'(bus.db_estado), 32'(exp_db));

            // Stimulus for the rest of cycle c.
            bus.iniciar = (c == v.repulse);
            if (c == v.drop_cycle) bus.limite = v.drop_val;
            ovr_en  = 1'b0;
            ovr_val = 4'h0;
            if (c <= v.fim_cycle && k == 0 && i == v.zero_entry) begin
                ovr_en  = 1'b1;
                ovr_val = 4'h0;
            end else if (c <= v.fim_cycle && v.glitch && k >= 1 && k <= T_ON) begin
                ovr_en  = 1'b1;
                ovr_val = 4'hF;
            end
            tick();
        end
        bus.iniciar = 1'b0;
        ovr_en      = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, " leds"}, 32'(bus.leds), 32'h0);
        check({name, " addr"}, 32'(bus.mem_addr), 32'h0);
        check({name, " ocupado"}, 32'(bus.ocupado), 32'h0);
        check({name, " fim"}, 32'(bus.fim), 32'h0);
        check({name, " db_estado"}, 32'(bus.db_estado), 32'h0);
    endtask

    vec_t vecs[5];

    initial begin
        bool_seen_fim_blk : begin end
    end

    initial begin
        bit seen;

        vecs[0] = '{"lim0",    4'd0,   7, 4'd0,  -1, -1, 1'b0, -1, 4'd0};
        vecs[1] = '{"lim3",    4'd3,  28, 4'd3,  -1, -1, 1'b0, -1, 4'd0};
        vecs[2] = '{"repulse", 4'd3,  28, 4'd3,   9, -1, 1'b0, -1, 4'd0};
        vecs[3] = '{"lim15",   4'd15, 112, 4'd15, -1, -1, 1'b0, -1, 4'd0};
        vecs[4] = '{"drop",    4'd5,  112, 4'd15, -1, -1, 1'b0, 30, 4'd2};

        bus.iniciar = 1'b0;
        bus.limite  = 4'd0;

        // Power-on reset.
        #2;
        check_idle("por");
        @(negedge clock);
        reset = 1'b1;
        tick();

        for (int n = 0; n < 5; n++) begin
            run_vec(vecs[n]);
            tick();
        end

        // Reset mid-clock during MOSTRA of entry 2, then a clean restart.
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        repeat (15) tick();
        check("pre-reset leds", 32'(bus.leds), 32'h4);
        #3;
        reset = 1'b0;
        #1;
        check_idle("async reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_vec('{"restart", 4'd1, 14, 4'd1, -1, -1, 1'b0, -1, 4'd0});
        tick();

        // Sampled ROM data: glitches during MOSTRA are ignored, and a zero
        // entry shows blank with unchanged timing.
        run_vec('{"dado", 4'd1, 14, 4'd1, -1, 1, 1'b1, -1, 4'd0});
        tick();

        // iniciar held across FIM: one INICIAL cycle, then a new run.
        bus.limite  = 4'd0;
        bus.iniciar = 1'b1;
        tick();
        repeat (6) tick();
        check("hold c7 fim", 32'(bus.fim), 32'h1);
        tick();
        check("hold c8 ocupado", 32'(bus.ocupado), 32'h0);
        check("hold c8 db_estado", 32'(bus.db_estado), 32'h0);
        tick();
        check("hold c9 db_estado", 32'(bus.db_estado), 32'h1);
        bus.iniciar = 1'b0;
        tick();
        check("hold c10 leds", 32'(bus.leds), 32'h1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (bus.fim) seen = 1'b1;
        end
        check("hold second fim seen", 32'(seen), 32'h1);
        tick();
        check("hold end db_estado", 32'(bus.db_estado), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
